config_reg_bank: RTL and testbench
==================================

Name: config_reg_bank

Overview:
- Parametrised successor to the single config register: a bank of NUM_REGS configuration registers of DATA_W bits each.
- Each register is double-buffered. Bus writes land in a shadow copy, and a commit pulse transfers all shadows to the active copies atomically.
- Active copies drive downstream blocks (temp sensor thresholds, modes).
- Adds registered read-back, write lock, dirty tracking and an access-error flag.

Parameters:
- DATA_W, 16, register width in bits.
- NUM_REGS, 8, number of registers (2..64; need not be a power of 2).
- ADDR_W, 3, address width; must satisfy 2**ADDR_W >= NUM_REGS.
- RESET_VAL, all zeros, packed NUM_REGS*DATA_W reset image. Register i is RESET_VAL[i*DATA_W +: DATA_W].

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- write  input  1  write strobe, sampled at rising clk.
- read  input  1  read strobe, sampled at rising clk.
- address  input  ADDR_W  register index for read and write.
- data_in  input  DATA_W  write data.
- commit  input  1  one-cycle pulse: copy all shadows to active.
- lock  input  1  when high, bus writes are rejected.
- data_out  output  DATA_W  registered read data.
- rd_valid  output  1  pulses high the cycle data_out is updated by a read.
- err  output  1  one-cycle pulse on an illegal access.
- dirty  output  1  high when a shadow differs in history from active (an accepted write is not yet committed).
- cfg_active  output  NUM_REGS*DATA_W  flattened active registers; register i is at [i*DATA_W +: DATA_W].

Behaviour:
- Reset (reset low, asynchronous, takes effect immediately):
  - shadow[i] = active[i] = RESET_VAL slice.
  - data_out = 0, rd_valid = 0, err = 0, dirty = 0.
  - Release is synchronous to clk. The first edge with reset high is a normal cycle.
- Legal address: address < NUM_REGS.
- Accepted write: write && !lock && legal address. shadow[address] <= data_in at that edge, and dirty <= 1.
- Rejected write: write && (lock || illegal address). No state change; err pulses high the next cycle.
- Read:
  - read && legal address: data_out <= shadow[address], rd_valid <= 1. Latency is 1 cycle.
  - read && illegal address: data_out <= 0, rd_valid <= 1, err <= 1.
  - No read: rd_valid <= 0 and data_out holds its value.
- Simultaneous read and write to the same address: read returns the pre-write shadow value (read-before-write). The write still takes effect.
- Commit:
  - On commit, active[i] <= shadow[i] for all i.
  - If an accepted write occurs in the same cycle, the commit copies the pre-write shadow. The new value stays in shadow only and dirty stays 1.
  - Otherwise dirty <= 0.
- Commit while lock is high is permitted. Lock gates bus writes only.
- cfg_active changes only on commit or reset, never mid-cycle from bus writes.
- err is a single-cycle pulse per offending access. Back-to-back bad accesses give a continuous high.
- Reset asserted mid-operation aborts everything. Uncommitted writes are lost and the shadows revert to RESET_VAL.
- Inputs are assumed synchronous to clk. No internal synchronisers.

Decomposition:
- Package config_reg_pkg:
  - default DATA_W and NUM_REGS constants.
  - a function returning the reset slice for index i.
  - helper localparam for the legal-address check.
- Sub-module config_reg_slot, instantiated NUM_REGS times via generate:
  - holds one shadow/active pair.
  - inputs: wr_en, commit, d, rst_val.
  - outputs: shadow_q, active_q.
- Top level holds address decode, read mux/register, err, rd_valid and dirty logic.

Test Plan:
- Reset image: RESET_VAL reg2=16'h00A5, others 0; assert reset low for 3 cycles then release -> cfg_active reg2 = 16'h00A5, data_out=0, dirty=0, err=0.
- Write/read latency: write 16'h0001 to addr 3, then read addr 3 next cycle -> data_out=16'h0001 with rd_valid high exactly 1 cycle after the read; cfg_active reg3 unchanged; dirty=1.
- Commit: after the above, pulse commit -> next cycle cfg_active reg3=16'h0001, dirty=0. Write and commit in the same cycle to addr 4 with 16'hBEEF -> active reg4 keeps its old value and dirty stays 1. A second commit gives active reg4=16'hBEEF.
- Lock: lock=1, write 16'h1234 to addr 1 -> err pulses 1 cycle; read addr 1 returns the prior value; dirty unchanged.
- Illegal address (NUM_REGS=6, ADDR_W=3): write to addr 7 -> err pulse, no register changes. Read addr 6 -> data_out=0, rd_valid=1, err=1.
- Reset mid-operation: write 16'hFFFF to addr 0, assert reset before commit -> shadow and active reg0 = RESET_VAL slice; a read after release returns the reset value.

Source files
------------

// File: rtl/config_reg_pkg.sv
// Shared constants and helpers for the double-buffered configuration register bank.
package config_reg_pkg;

    localparam int DEFAULT_DATA_W   = 16;
    localparam int DEFAULT_NUM_REGS = 8;
    localparam int DEFAULT_ADDR_W   = 3;

    // Upper bounds used to size the reset-image helper below.
    localparam int MAX_DATA_W   = 32;
    localparam int MAX_NUM_REGS = 64;
    localparam int MAX_IMG_W    = MAX_DATA_W * MAX_NUM_REGS;

    // Reset value of register idx taken from a packed reset image whose
    // registers are data_w bits wide. Callers truncate to their own width.
    function automatic logic [MAX_DATA_W-1:0] reset_slice(
        input logic [MAX_IMG_W-1:0] img,
        input int unsigned          idx,
        input int unsigned          data_w
    );
        return MAX_DATA_W'(img >> (idx * data_w));
    endfunction

    // True when every encodable address maps to a register, so no address
    // can be illegal and the range comparator collapses to a constant.
    function automatic bit addr_space_full(input int addr_w, input int num_regs);
        return (2 ** addr_w) == num_regs;
    endfunction

endpackage

// File: rtl/config_reg_slot.sv
// One double-buffered configuration register: a bus-written shadow copy and
// an active copy that only changes when the bank commits.
module config_reg_slot
    import config_reg_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              commit,
    input  logic [DATA_W-1:0] d,
    input  logic [DATA_W-1:0] rst_val,
    output logic [DATA_W-1:0] shadow_q,
    output logic [DATA_W-1:0] active_q
);

    // Shadow takes bus writes; active takes the pre-edge shadow on commit.
    // NOTE: non-blocking assignments make active_q sample the old shadow_q, so a
    // write and a commit on the same edge commit the value from before the write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= rst_val;
            active_q <= rst_val;
        end else begin
            if (wr_en) begin
                shadow_q <= d;
            end
            if (commit) begin
                active_q <= shadow_q;
            end
        end
    end

endmodule

// File: rtl/config_reg_bank.sv
// Bank of double-buffered configuration registers with registered read-back,
// write lock, dirty tracking and an access-error pulse.
module config_reg_bank
    import config_reg_pkg::*;
#(
    parameter int                             DATA_W    = DEFAULT_DATA_W,
    parameter int                             NUM_REGS  = DEFAULT_NUM_REGS,
    parameter int                             ADDR_W    = DEFAULT_ADDR_W,
    parameter logic [NUM_REGS*DATA_W-1:0]     RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       write,
    input  logic                       read,
    input  logic [ADDR_W-1:0]          address,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       commit,
    input  logic                       lock,
    output logic [DATA_W-1:0]          data_out,
    output logic                       rd_valid,
    output logic                       err,
    output logic                       dirty,
    output logic [NUM_REGS*DATA_W-1:0] cfg_active
);

    localparam bit                    ALL_LEGAL = addr_space_full(ADDR_W, NUM_REGS);
    localparam logic [MAX_IMG_W-1:0] RESET_IMG = MAX_IMG_W'(RESET_VAL);

    logic [DATA_W-1:0] shadow [NUM_REGS];
    logic [DATA_W-1:0] active [NUM_REGS];
    logic [DATA_W-1:0] rd_mux;
    logic              addr_legal;
    logic              wr_accept;
    logic              bad_access;

    assign addr_legal = ALL_LEGAL ? 1'b1
                                  : ({1'b0, address} < (ADDR_W+1)'(NUM_REGS));
    assign wr_accept  = write && !lock && addr_legal;
    assign bad_access = (write && (lock || !addr_legal)) || (read && !addr_legal);

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_slot
        config_reg_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk      (clk),
            .rst_n    (reset),
            .wr_en    (wr_accept && (address == ADDR_W'(i))),
            .commit   (commit),
            .d        (data_in),
            .rst_val  (DATA_W'(reset_slice(RESET_IMG, i, DATA_W))),
            .shadow_q (shadow[i]),
            .active_q (active[i])
        );
        assign cfg_active[i*DATA_W +: DATA_W] = active[i];
    end

    // Read mux over the shadows; an out-of-range address selects zero.
    // NOTE: the default assignment before the loop keeps this purely
    // combinational; without it an unmatched address would infer a latch.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (address == ADDR_W'(i)) begin
                rd_mux = shadow[i];
            end
        end
    end

    // Registered read-back: data_out holds between reads, rd_valid marks an update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= read;
            if (read) begin
                data_out <= rd_mux;
            end
        end
    end

    // One-cycle error pulse per rejected write or out-of-range read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else begin
            err <= bad_access;
        end
    end

    // Dirty is set by any accepted write and cleared by a commit that does not
    // coincide with one; a same-cycle write leaves its value uncommitted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dirty <= 1'b0;
        end else if (wr_accept) begin
            dirty <= 1'b1;
        end else if (commit) begin
            dirty <= 1'b0;
        end
    end

endmodule

// File: tb/tb_config_reg_bank.sv
// Self-checking bench for config_reg_bank: directed scenarios with literal
// expectations, then randomized traffic compared every cycle to a model.
module tb_config_reg_bank;

    localparam int DW = 16;
    localparam int NR = 6;
    localparam int AW = 3;
    localparam logic [NR*DW-1:0] RV = 96'h0000_0000_0000_00A5_0000_0000;

    logic              clk;
    logic              reset;
    logic              write;
    logic              read;
    logic [AW-1:0]     address;
    logic [DW-1:0]     data_in;
    logic              commit;
    logic              lock;
    logic [DW-1:0]     data_out;
    logic              rd_valid;
    logic              err;
    logic              dirty;
    logic [NR*DW-1:0]  cfg_active;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 0;

    config_reg_bank #(
        .DATA_W    (DW),
        .NUM_REGS  (NR),
        .ADDR_W    (AW),
        .RESET_VAL (RV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .write      (write),
        .read       (read),
        .address    (address),
        .data_in    (data_in),
        .commit     (commit),
        .lock       (lock),
        .data_out   (data_out),
        .rd_valid   (rd_valid),
        .err        (err),
        .dirty      (dirty),
        .cfg_active (cfg_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [DW-1:0] m_sh  [NR];
    logic [DW-1:0] m_act [NR];
    logic [DW-1:0] m_do;
    logic          m_rv, m_err, m_dirty;
    logic          m_legal, m_wok;

    assign m_legal = (int'(address) < NR);
    assign m_wok   = write && !lock && m_legal;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NR; i++) begin
                m_sh[i]  <= RV[i*DW +: DW];
                m_act[i] <= RV[i*DW +: DW];
            end
            m_do    <= '0;
            m_rv    <= 1'b0;
            m_err   <= 1'b0;
            m_dirty <= 1'b0;
        end else begin
            m_rv  <= read;
            if (read) m_do <= m_legal ? m_sh[address] : '0;
            m_err <= (write && (lock || !m_legal)) || (read && !m_legal);
            if (commit) begin
                for (int i = 0; i < NR; i++) m_act[i] <= m_sh[i];
            end
            if (m_wok) begin
                m_sh[address] <= data_in;
                m_dirty       <= 1'b1;
            end else if (commit) begin
                m_dirty <= 1'b0;
            end
        end
    end

    // Compare outputs against the model half a cycle after each edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            logic [NR*DW-1:0] exp_act;
            for (int i = 0; i < NR; i++) exp_act[i*DW +: DW] = m_act[i];
            check("data_out", data_out, m_do);
            check("rd_valid", rd_valid, m_rv);
            check("err", err, m_err);
            check("dirty", dirty, m_dirty);
            check("cfg_active", cfg_active, exp_act);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic w, input logic r, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic c, input logic l);
        write   = w;
        read    = r;
        address = a;
        data_in = d;
        commit  = c;
        lock    = l;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        write = 0; read = 0; address = '0; data_in = '0; commit = 0; lock = 0;
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b1;
        cmp_en = 1;

        // Reset image
        check("rst_reg2", cfg_active[2*DW +: DW], 16'h00A5);
        check("rst_reg3", cfg_active[3*DW +: DW], 16'h0000);
        check("rst_data_out", data_out, 16'h0000);
        check("rst_dirty", dirty, 1'b0);
        check("rst_err", err, 1'b0);

        // Write then read with one-cycle latency
        step(1, 0, 3, 16'h0001, 0, 0);
        check("wr_dirty", dirty, 1'b1);
        check("wr_rd_valid_idle", rd_valid, 1'b0);
        step(0, 1, 3, 16'h0000, 0, 0);
        check("rd_data", data_out, 16'h0001);
        check("rd_valid", rd_valid, 1'b1);
        check("rd_act3_unchanged", cfg_active[3*DW +: DW], 16'h0000);
        step(0, 0, 0, 16'h0000, 0, 0);
        check("rd_valid_drop", rd_valid, 1'b0);
        check("rd_data_hold", data_out, 16'h0001);

        // Commit, then write+commit in the same cycle
        step(0, 0, 0, 16'h0000, 1, 0);
        check("commit_act3", cfg_active[3*DW +: DW], 16'h0001);
        check("commit_dirty", dirty, 1'b0);
        step(1, 0, 4, 16'hBEEF, 1, 0);
        check("wc_act4_old", cfg_active[4*DW +: DW], 16'h0000);
        check("wc_dirty", dirty, 1'b1);
        step(0, 0, 0, 16'h0000, 1, 0);
        check("commit2_act4", cfg_active[4*DW +: DW], 16'hBEEF);
        check("commit2_dirty", dirty, 1'b0);

        // Lock rejects writes
        step(1, 0, 1, 16'h1234, 0, 1);
        check("lock_err", err, 1'b1);
        check("lock_dirty", dirty, 1'b0);
        step(0, 1, 1, 16'h0000, 0, 0);
        check("lock_err_drop", err, 1'b0);
        check("lock_rd1", data_out, 16'h0000);

        // Illegal addresses
        step(0, 1, 3, 16'h0000, 0, 0);
        check("pre_ill_rd3", data_out, 16'h0001);
        step(1, 0, 7, 16'h5555, 0, 0);
        check("ill_wr_err", err, 1'b1);
        check("ill_wr_dirty", dirty, 1'b0);
        step(0, 1, 6, 16'h0000, 0, 0);
        check("ill_rd_data", data_out, 16'h0000);
        check("ill_rd_valid", rd_valid, 1'b1);
        check("ill_rd_err", err, 1'b1);

        // Read-before-write on the same address
        step(1, 1, 3, 16'h0007, 0, 0);
        check("rbw_old", data_out, 16'h0001);
        step(0, 1, 3, 16'h0000, 0, 0);
        check("rbw_new", data_out, 16'h0007);

        // Reset mid-operation discards uncommitted writes
        step(1, 0, 0, 16'hFFFF, 0, 0);
        write = 0;
        #2 reset = 1'b0;
        #1;
        check("mid_rst_act0", cfg_active[0*DW +: DW], 16'h0000);
        check("mid_rst_act2", cfg_active[2*DW +: DW], 16'h00A5);
        check("mid_rst_act4", cfg_active[4*DW +: DW], 16'h0000);
        check("mid_rst_dirty", dirty, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        step(0, 1, 0, 16'h0000, 0, 0);
        check("mid_rst_rd0", data_out, 16'h0000);
        check("mid_rst_rv", rd_valid, 1'b1);
        step(0, 1, 2, 16'h0000, 0, 0);
        check("mid_rst_rd2", data_out, 16'h00A5);

        // Randomized traffic, checked every cycle by the compare process
        for (int n = 0; n < 2000; n++) begin
            reset = ($urandom_range(0, 299) != 0);
            step($urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1,
                 AW'($urandom_range(0, 7)),
                 DW'($urandom),
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) == 0);
        end
        reset = 1'b1;
        step(0, 0, 0, 16'h0000, 0, 0);
        @(negedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
